// File: rtl/mbm_pkg.sv
// Shared definitions for the MBM (Mitchell-based multiplier) shared-resource blocks.
package mbm_pkg;

    localparam int unsigned MBM_N = 8;
    localparam int unsigned MBM_L = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOD   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } mbm_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mbm_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request above ptr, wrapping to 0.
module mbm_rr_arbiter #(
    parameter int unsigned R  = 4,
    parameter int unsigned TW = 2
) (
    input  logic [R-1:0]  req,
    input  logic [TW-1:0] ptr,
    output logic [R-1:0]  grant,
    output logic [TW-1:0] idx
);

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        // Indices strictly above ptr first, then wrap around to 0..ptr.
        for (int i = 0; i < R; i++) begin
            if (!found && req[i] && (TW'(i) > ptr)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = TW'(i);
            end
        end
        for (int i = 0; i < R; i++) begin
            if (!found && req[i] && (TW'(i) <= ptr)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = TW'(i);
            end
        end
    end

endmodule

// File: rtl/mbm_mult_scheduler.sv
// Shares one multi-cycle Mitchell log-multiplier among R requesters via round-robin
// arbitration; the result returns on a tagged valid/ready channel.
module mbm_mult_scheduler
    import mbm_pkg::*;
#(
    parameter int unsigned N  = MBM_N,
    parameter int unsigned L  = MBM_L,
    parameter int unsigned R  = 4,
    parameter int unsigned TW = clog2(R)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [R-1:0]     req_valid,
    input  logic [R*N-1:0]   req_a,
    input  logic [R*N-1:0]   req_b,
    output logic [R-1:0]     req_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2*N-1:0]   res_product,
    output logic [TW-1:0]    res_tag,
    output logic [L:0]       res_char,
    output logic             res_zero,
    output logic             busy
);

    mbm_state_e    state;
    logic [TW-1:0] rr_ptr;
    logic [TW-1:0] tag_q;
    logic [R-1:0]  gnt;
    logic [TW-1:0] gnt_idx;
    logic [N-1:0]  sel_a, sel_b;
    logic [N-1:0]  a_q, b_q;
    logic [L-1:0]  k1_c, k2_c, k1_q, k2_q;
    logic [N-2:0]  x1_c, x2_c, x1_q, x2_q;
    logic          zero_q;
    logic [N-1:0]  s_c;
    logic [L:0]    char_c, char_q;
    logic [N-1:0]  m_q;
    logic [2*N-1:0] prod_c;

    function automatic logic [L-1:0] lod(input logic [N-1:0] v);
        logic [L-1:0] k;
        k = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                k = L'(i);
            end
        end
        return k;
    endfunction

    mbm_rr_arbiter #(
        .R  (R),
        .TW (TW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    assign req_ready = (state == IDLE) ? gnt : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < R; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[i*N +: N];
                sel_b = req_b[i*N +: N];
            end
        end
    end

    always_comb begin
        k1_c   = lod(a_q);
        k2_c   = lod(b_q);
        // Normalise so the leading one sits at bit N-1, then drop it.
        x1_c   = (N-1)'(a_q << (L'(N - 1) - k1_c));
        x2_c   = (N-1)'(b_q << (L'(N - 1) - k2_c));
        s_c    = {1'b0, x1_q} + {1'b0, x2_q};
        char_c = {1'b0, k1_q} + {1'b0, k2_q} + {{L{1'b0}}, s_c[N-1]};
        if (char_q >= (L+1)'(N - 1)) begin
            prod_c = (2*N)'(m_q) << (char_q - (L+1)'(N - 1));
        end else begin
            prod_c = (2*N)'(m_q) >> ((L+1)'(N - 1) - char_q);
        end
        if (zero_q) begin
            prod_c = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= TW'(R - 1);
            tag_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            k1_q        <= '0;
            k2_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            zero_q      <= 1'b0;
            char_q      <= '0;
            m_q         <= '0;
            res_valid   <= 1'b0;
            res_product <= '0;
            res_tag     <= '0;
            res_char    <= '0;
            res_zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        tag_q  <= gnt_idx;
                        rr_ptr <= gnt_idx;
                        state  <= LOD;
                    end
                end
                LOD: begin
                    k1_q   <= k1_c;
                    k2_q   <= k2_c;
                    x1_q   <= x1_c;
                    x2_q   <= x2_c;
                    zero_q <= (a_q == '0) | (b_q == '0);
                    state  <= ADD;
                end
                ADD: begin
                    char_q <= char_c;
                    m_q    <= {1'b1, s_c[N-2:0]};
                    state  <= SHIFT;
                end
                SHIFT: begin
                    res_product <= prod_c;
                    res_char    <= char_q;
                    res_zero    <= zero_q;
                    res_tag     <= tag_q;
                    res_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbm_mult_scheduler.sv
// Scoreboard bench for mbm_mult_scheduler: accepts push expected results, a monitor pops them.
module tb_mbm_mult_scheduler;

    localparam int N  = 8;
    localparam int L  = 3;
    localparam int R  = 4;
    localparam int TW = 2;

    logic             clk;
    logic             rst;
    logic [R-1:0]     req_valid;
    logic [R*N-1:0]   req_a;
    logic [R*N-1:0]   req_b;
    logic [R-1:0]     req_ready;
    logic             res_valid;
    logic             res_ready;
    logic [2*N-1:0]   res_product;
    logic [TW-1:0]    res_tag;
    logic [L:0]       res_char;
    logic             res_zero;
    logic             busy;

    mbm_mult_scheduler #(
        .N  (N),
        .L  (L),
        .R  (R),
        .TW (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_product (res_product),
        .res_tag     (res_tag),
        .res_char    (res_char),
        .res_zero    (res_zero),
        .busy        (busy)
    );

    typedef struct {
        int tag;
        int prod;
        int chr;
        int zero;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   acc_tag[$];
    int   acc_cyc[$];
    int   op_prod[R];
    int   op_char[R];
    int   op_zero[R];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_hs = -1;
    logic prev_v = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Accept watcher: every handshake on req_ready pushes the hand-computed result.
    always @(negedge clk) begin
        if (!rst && req_ready != '0) begin
            int   k;
            exp_t e;
            k = 0;
            for (int i = 0; i < R; i++) if (req_ready[i]) k = i;
            chk("ready_onehot", $countones(req_ready), 1);
            e.tag  = k;
            e.prod = op_prod[k];
            e.chr  = op_char[k];
            e.zero = op_zero[k];
            e.acc  = cyc;
            exp_q.push_back(e);
            acc_tag.push_back(k);
            acc_cyc.push_back(cyc);
        end
    end

    // Result monitor.
    always @(negedge clk) begin
        if (rst) begin
            prev_v <= 1'b0;
        end else begin
            if (|req_valid && busy) chk("ready_while_busy", int'(req_ready), 0);
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got tag %0d expected no result", res_tag);
                end else begin
                    chk("res_tag", int'(res_tag), exp_q[0].tag);
                    chk("res_product", int'(res_product), exp_q[0].prod);
                    chk("res_char", int'(res_char), exp_q[0].chr);
                    chk("res_zero", int'(res_zero), exp_q[0].zero);
                    if (!prev_v) chk("latency", cyc - exp_q[0].acc, 4);
                    if (res_ready) begin
                        void'(exp_q.pop_front());
                        last_hs <= cyc;
                    end
                end
            end
            prev_v <= res_valid;
        end
    end

    task automatic set_op(input int i, input int a, input int b, input int p, input int c,
                          input int z);
        req_a[i*N +: N] = N'(a);
        req_b[i*N +: N] = N'(b);
        op_prod[i] = p;
        op_char[i] = c;
        op_zero[i] = z;
    endtask

    task automatic issue(input int i);
        int n0;
        @(posedge clk);
        #1;
        n0 = acc_tag.size();
        req_valid[i] = 1'b1;
        for (int t = 0; t < 50 && acc_tag.size() == n0; t++) @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        if (acc_tag.size() == n0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected requester %0d", i);
        end else begin
            chk("grant_tag", acc_tag[acc_tag.size()-1], i);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n0;
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_product", int'(res_product), 0);
        chk("rst_tag", int'(res_tag), 0);
        chk("rst_char", int'(res_char), 0);
        chk("rst_zero", int'(res_zero), 0);
        rst = 1'b0;

        // Basic vectors
        set_op(0, 3, 5, 14, 3, 0);
        issue(0);
        drain();
        set_op(2, 7, 7, 48, 5, 0);
        issue(2);
        drain();
        set_op(2, 255, 255, 65024, 15, 0);
        issue(2);
        drain();
        set_op(1, 0, 200, 0, 7, 1);
        issue(1);
        drain();

        // Round robin with all requesters active, from a fresh reset
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        set_op(0, 3, 5, 14, 3, 0);
        set_op(1, 7, 7, 48, 5, 0);
        set_op(2, 255, 255, 65024, 15, 0);
        set_op(3, 2, 3, 6, 2, 0);
        n0 = acc_tag.size();
        req_valid = '1;
        for (int t = 0; t < 100 && acc_tag.size() < n0 + 6; t++) @(posedge clk);
        #1;
        req_valid = '0;
        chk("rr_count", acc_tag.size() - n0, 6);
        if (acc_tag.size() >= n0 + 6) begin
            for (int j = 0; j < 6; j++) begin
                chk("rr_order", acc_tag[n0+j], j % R);
                if (j > 0) chk("rr_interval", acc_cyc[n0+j] - acc_cyc[n0+j-1], 5);
            end
        end
        drain();

        // Back-pressure: hold DONE for 10 cycles with another requester waiting
        res_ready = 1'b0;
        set_op(2, 7, 7, 48, 5, 0);
        issue(2);
        for (int t = 0; t < 20 && !res_valid; t++) @(negedge clk);
        chk("stall_valid", int'(res_valid), 1);
        set_op(0, 3, 5, 14, 3, 0);
        req_valid[0] = 1'b1;
        repeat (10) @(negedge clk);
        chk("stall_still_valid", int'(res_valid), 1);
        @(posedge clk);
        #1;
        n0 = acc_tag.size();
        res_ready = 1'b1;
        for (int t = 0; t < 20 && acc_tag.size() == n0; t++) @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        chk("release_accept", acc_tag.size() - n0, 1);
        if (acc_tag.size() > n0) begin
            chk("release_tag", acc_tag[n0], 0);
            chk("release_next_cycle", acc_cyc[n0] - last_hs, 1);
        end
        drain();

        // Reset while req3 sits in ADD: no result may appear for it
        set_op(3, 2, 3, 6, 2, 0);
        issue(3);
        @(posedge clk);
        #1;
        chk("busy_in_add", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", int'(res_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        set_op(0, 3, 5, 14, 3, 0);
        n0 = acc_tag.size();
        req_valid = 4'b1001;
        for (int t = 0; t < 50 && acc_tag.size() < n0 + 1; t++) @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        for (int t = 0; t < 50 && acc_tag.size() < n0 + 2; t++) @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        chk("post_rst_count", acc_tag.size() - n0, 2);
        if (acc_tag.size() >= n0 + 2) begin
            chk("post_rst_first", acc_tag[n0], 0);
            chk("post_rst_second", acc_tag[n0+1], 3);
        end
        drain();
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
